edge_oneshot_multi: RTL and testbench

Parametrised multi-channel edge-to-pulse converter that supersedes the single-channel rising-edge one-shot. Each channel has:
- a synchroniser for asynchronous inputs
- a debounce filter
- an edge detector with selectable rising, falling or both-edge mode
- a pulse stretcher

It sits between the board button/switch or ADC-control inputs and the control FSMs that consume single-cycle or fixed-width command strobes.

---
 rtl/edge_oneshot_pkg.sv | 17 +
 rtl/edge_oneshot_chan.sv | 82 ++++++++
 rtl/edge_oneshot_multi.sv | 59 +++++
 tb/tb_edge_oneshot_multi.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_oneshot_pkg.sv
// Shared definitions for the edge_oneshot_multi slice: edge-select encodings and a width helper.
package edge_oneshot_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;

  // Bits needed to hold the values 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/edge_oneshot_chan.sv
// One channel of edge_oneshot_multi: synchroniser, debounce filter, edge qualifier and pulse stretcher.
module edge_oneshot_chan
  import edge_oneshot_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 16,
  parameter int   PULSE_LEN   = 1,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic       level,
  output logic       evt
);

  localparam int          CNT_W     = clog2(DB_CYCLES + 1);
  localparam int          PCNT_W    = clog2(PULSE_LEN);
  localparam int unsigned DB_LAST_I = DB_CYCLES - 1;
  localparam int unsigned P_LOAD_I  = PULSE_LEN - 1;
  localparam logic [CNT_W-1:0]  DB_LAST = DB_LAST_I[CNT_W-1:0];
  localparam logic [PCNT_W-1:0] P_LOAD  = P_LOAD_I[PCNT_W-1:0];

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt_q;
  logic [PCNT_W-1:0]      pcnt_q;
  logic                   toggle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign toggle = (s != level) && (cnt_q == DB_LAST);

  // Any sample that agrees with the accepted level restarts the persistence count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      level <= INIT_LEVEL;
    end else if (s == level) begin
      cnt_q <= '0;
    end else if (toggle) begin
      level <= s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    evt = 1'b0;
    if (toggle) begin
      case (mode)
        EDGE_RISE: evt = s;
        EDGE_FALL: evt = ~s;
        EDGE_BOTH: evt = 1'b1;
        default:   evt = 1'b0;
      endcase
    end
  end

  // A fresh event reloads the count, so back-to-back events merge into one longer pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse  <= 1'b0;
      pcnt_q <= '0;
    end else if (evt) begin
      pulse  <= 1'b1;
      pcnt_q <= P_LOAD;
    end else if (pcnt_q != '0) begin
      pcnt_q <= pcnt_q - PCNT_W'(1);
    end else begin
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_oneshot_multi.sv
// Multi-channel debounced edge-to-pulse converter with registered any_pulse.
// Optional sticky event flags are built only when EDGE_ONESHOT_STICKY_EN is defined.
module edge_oneshot_multi
  import edge_oneshot_pkg::*;
#(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_CYCLES   = 16,
  parameter int   PULSE_LEN   = 1,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] din,
  input  logic [1:0]    mode,
  output logic [CH-1:0] pulse,
  output logic [CH-1:0] level,
  output logic          any_pulse,
  output logic [CH-1:0] sticky,
  input  logic [CH-1:0] clr_sticky
);

  logic [CH-1:0] evt;

  for (genvar i = 0; i < CH; i++) begin : g_chan
    edge_oneshot_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .PULSE_LEN   (PULSE_LEN),
      .INIT_LEVEL  (INIT_LEVEL)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (din[i]),
      .mode  (mode),
      .pulse (pulse[i]),
      .level (level[i]),
      .evt   (evt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_pulse <= 1'b0;
    else        any_pulse <= |pulse;
  end

`ifdef EDGE_ONESHOT_STICKY_EN
  // The set term is OR-ed last so an event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky <= '0;
    else        sticky <= (sticky & ~clr_sticky) | evt;
  end
`else
  logic [2*CH-1:0] unused_sticky_inputs;
  assign unused_sticky_inputs = {clr_sticky, evt};
  assign sticky = '0;
`endif

endmodule

// File: tb/tb_edge_oneshot_multi.sv
// Self-checking bench for edge_oneshot_multi: directed vector table, corner sequences and
// randomized stimulus against a cycle-level reference model. Honours EDGE_ONESHOT_STICKY_EN.
module tb_edge_oneshot_multi;
  import edge_oneshot_pkg::*;

  localparam int   CH          = 4;
  localparam int   SYNC_STAGES = 2;
  localparam int   DB_CYCLES   = 4;
  localparam int   PULSE_LEN   = 6;
  localparam logic INIT_LEVEL  = 1'b0;
  localparam int   LAT         = SYNC_STAGES + DB_CYCLES;
`ifdef EDGE_ONESHOT_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [CH-1:0] din;
  logic [1:0]    mode;
  logic [CH-1:0] pulse;
  logic [CH-1:0] level;
  logic          any_pulse;
  logic [CH-1:0] sticky;
  logic [CH-1:0] clr_sticky;

  int n_checks;
  int n_fail;

  edge_oneshot_multi #(
    .CH          (CH),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES),
    .PULSE_LEN   (PULSE_LEN),
    .INIT_LEVEL  (INIT_LEVEL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .mode       (mode),
    .pulse      (pulse),
    .level      (level),
    .any_pulse  (any_pulse),
    .sticky     (sticky),
    .clr_sticky (clr_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: s is the input seen SYNC_STAGES edges ago, a level is accepted after
  // DB_CYCLES consecutive disagreeing samples, and a pulse lasts PULSE_LEN cycles from the last event.
  logic [CH-1:0] m_hist [$];
  logic [CH-1:0] m_level, m_pulse, m_sticky;
  logic          m_any;
  int            m_run  [CH];
  int            m_last [CH];
  int            m_cyc;

  int            pcyc  [CH];
  int            prise [CH];
  int            anyc;
  logic [CH-1:0] last_pulse;

  typedef struct {
    logic [CH-1:0]   din;
    logic [1:0]      mode;
    int              cycles;
    logic [CH-1:0]   exp_level;
    logic [CH*8-1:0] exp_pcyc;
    int              exp_anyc;
  } vec_t;
  vec_t vecs [$];

  function automatic logic qualifies(input logic new_level, input logic [1:0] m);
    if (m == EDGE_BOTH) return 1'b1;
    if (new_level) return m == EDGE_RISE;
    return m == EDGE_FALL;
  endfunction

  task automatic modelReset();
    m_hist = {};
    for (int k = 0; k < SYNC_STAGES; k++) m_hist.push_back({CH{INIT_LEVEL}});
    m_level  = {CH{INIT_LEVEL}};
    m_pulse  = '0;
    m_sticky = '0;
    m_any    = 1'b0;
    m_cyc    = 0;
    for (int i = 0; i < CH; i++) begin
      m_run[i]  = 0;
      m_last[i] = -1000000;
    end
  endtask

  task automatic modelEdge();
    logic [CH-1:0] s;
    logic [CH-1:0] ev;
    logic [CH-1:0] prev_pulse;
    prev_pulse = m_pulse;
    ev = '0;
    s = m_hist.pop_front();
    m_hist.push_back(din);
    m_cyc++;
    for (int i = 0; i < CH; i++) begin
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DB_CYCLES) begin
          m_level[i] = s[i];
          m_run[i]   = 0;
          ev[i]      = qualifies(s[i], mode);
        end
      end else begin
        m_run[i] = 0;
      end
      if (ev[i]) m_last[i] = m_cyc;
      m_pulse[i] = (m_cyc - m_last[i]) < PULSE_LEN;
    end
    m_any = |prev_pulse;
    if (STICKY_ON) m_sticky = (m_sticky & ~clr_sticky) | ev;
    else           m_sticky = '0;
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic checkOutput();
    n_checks++;
    if ({level, pulse, any_pulse, sticky} !== {m_level, m_pulse, m_any, m_sticky}) begin
      n_fail++;
      $display("[TB] FAIL model cyc=%0d: got level=%b pulse=%b any=%b sticky=%b, expected level=%b pulse=%b any=%b sticky=%b",
               m_cyc, level, pulse, any_pulse, sticky, m_level, m_pulse, m_any, m_sticky);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic clearCounts();
    for (int i = 0; i < CH; i++) begin
      pcyc[i]  = 0;
      prise[i] = 0;
    end
    anyc = 0;
    last_pulse = pulse;
  endtask

  task automatic applyStimulus(input logic [CH-1:0] d, input logic [1:0] m,
                               input logic [CH-1:0] c, input int cycles);
    din = d;
    mode = m;
    clr_sticky = c;
    for (int k = 0; k < cycles; k++) begin
      tick();
      for (int i = 0; i < CH; i++) begin
        if (pulse[i]) pcyc[i]++;
        if (pulse[i] && !last_pulse[i]) prise[i]++;
      end
      if (any_pulse) anyc++;
      last_pulse = pulse;
    end
  endtask

  task automatic doReset(input logic [CH-1:0] d);
    rst_n = 1'b0;
    din = d;
    clr_sticky = '0;
    modelReset();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic addVec(input logic [CH-1:0] d, input logic [1:0] m, input int cycles,
                        input logic [CH-1:0] lvl, input logic [CH*8-1:0] pc, input int ac);
    vec_t v;
    v.din = d; v.mode = m; v.cycles = cycles;
    v.exp_level = lvl; v.exp_pcyc = pc; v.exp_anyc = ac;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [CH*8-1:0] got_pc;
    logic [CH-1:0]   d;
    logic [CH-1:0]   c;
    logic [1:0]      m;
    int              first;

    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    din = '0;
    mode = EDGE_RISE;
    clr_sticky = '0;
    modelReset();
    doReset('0);
    checkValue("reset level", level, {CH{INIT_LEVEL}});
    checkValue("reset pulse", {pulse, any_pulse}, 0);

    // Pulse counts per channel are packed {ch3, ch2, ch1, ch0}.
    addVec(4'b0001, EDGE_RISE, 14, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd6}, 6);
    addVec(4'b0000, EDGE_RISE, 14, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b0010, EDGE_RISE,  3, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b0000, EDGE_RISE, 14, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b0010, EDGE_RISE,  4, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b0000, EDGE_RISE, 14, 4'b0000, {8'd0, 8'd0, 8'd6, 8'd0}, 6);
    addVec(4'b0100, EDGE_BOTH, 14, 4'b0100, {8'd0, 8'd6, 8'd0, 8'd0}, 6);
    addVec(4'b0000, EDGE_BOTH, 14, 4'b0000, {8'd0, 8'd6, 8'd0, 8'd0}, 6);
    addVec(4'b1000, EDGE_FALL, 14, 4'b1000, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b0000, EDGE_FALL, 14, 4'b0000, {8'd6, 8'd0, 8'd0, 8'd0}, 6);
    addVec(4'b1111, EDGE_OFF,  14, 4'b1111, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b0000, EDGE_OFF,  14, 4'b0000, {8'd0, 8'd0, 8'd0, 8'd0}, 0);
    addVec(4'b1111, EDGE_RISE, 14, 4'b1111, {8'd6, 8'd6, 8'd6, 8'd6}, 6);
    addVec(4'b0101, EDGE_BOTH, 14, 4'b0101, {8'd6, 8'd0, 8'd6, 8'd0}, 6);

    for (int k = 0; k < vecs.size(); k++) begin
      clearCounts();
      applyStimulus(vecs[k].din, vecs[k].mode, '0, vecs[k].cycles);
      for (int i = 0; i < CH; i++) got_pc[i*8 +: 8] = pcyc[i][7:0];
      checkValue($sformatf("vec%0d level", k), level, vecs[k].exp_level);
      checkValue($sformatf("vec%0d pulse cycles", k), got_pc, vecs[k].exp_pcyc);
      checkValue($sformatf("vec%0d any_pulse cycles", k), anyc, vecs[k].exp_anyc);
    end

    // Second event DB_CYCLES into the pulse: one continuous pulse of DB_CYCLES+PULSE_LEN.
    doReset('0);
    clearCounts();
    applyStimulus(4'b0001, EDGE_BOTH, '0, DB_CYCLES);
    applyStimulus(4'b0000, EDGE_BOTH, '0, 16);
    checkValue("extend pulse cycles", pcyc[0], DB_CYCLES + PULSE_LEN);
    checkValue("extend pulse starts", prise[0], 1);
    checkValue("extend any_pulse cycles", anyc, DB_CYCLES + PULSE_LEN);

    // Asynchronous reset during a pulse on ch0 and a debounce on ch1.
    doReset('0);
    applyStimulus(4'b0001, EDGE_RISE, '0, 8);
    checkValue("pre-reset pulse0", pulse[0], 1);
    applyStimulus(4'b0011, EDGE_RISE, '0, 3);
    checkValue("pre-reset level1", level[1], 0);
    #2 rst_n = 1'b0;
    #1;
    checkValue("async reset outputs", {level, pulse, any_pulse, sticky}, 0);
    modelReset();
    din = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    clearCounts();
    applyStimulus('0, EDGE_RISE, '0, 20);
    checkValue("no pulse after release", pcyc[0] + pcyc[1] + anyc, 0);

    // Input held high through reset yields one rising pulse after full latency.
    doReset(4'b0001);
    first = -1;
    for (int k = 1; k <= LAT + 4; k++) begin
      tick();
      if (pulse[0] && first < 0) first = k;
    end
    checkValue("power-up pulse edge", first, LAT);
    checkValue("power-up level", level, 4'b0001);

    // Sticky flag: set, hold, coincident set/clear, plain clear.
    doReset('0);
    applyStimulus(4'b1000, EDGE_RISE, '0, 14);
    checkValue("sticky set", sticky[3], STICKY_ON ? 32'd1 : 32'd0);
    applyStimulus(4'b0000, EDGE_RISE, '0, 14);
    checkValue("sticky hold", sticky, STICKY_ON ? 32'h8 : 32'h0);
    applyStimulus(4'b1000, EDGE_RISE, '0, LAT - 1);
    applyStimulus(4'b1000, EDGE_RISE, 4'b1000, 1);
    checkValue("sticky set wins", sticky[3], STICKY_ON ? 32'd1 : 32'd0);
    applyStimulus(4'b1000, EDGE_RISE, 4'b1000, 1);
    checkValue("sticky clear", sticky[3], 0);

    // Randomized traffic checked every cycle against the model.
    doReset('0);
    for (int n = 0; n < 3000; n++) begin
      d = din;
      c = '0;
      m = mode;
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 7) == 0) d[i] = ~d[i];
        if ($urandom_range(0, 7) == 0) c[i] = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) m = 2'($urandom_range(0, 3));
      applyStimulus(d, m, c, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
